pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter register and instruction-fetch sequencer for the 8-bit-PC RISC-V core.
- Drives `pc_current` into the +4 incrementer and takes back `pc_next`.
- Handles branch/jump redirects, issues requests to instruction memory and holds the fetched instruction until decode accepts it.
- Gates every fetch on the PMP execute check and raises a fetch fault, with a jump to the trap vector, on a PMP deny or a misaligned target.

Parameters:
- PC_W, 8, PC and address width
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, PC loaded on reset
- TRAP_VEC, 8'hF0, PC loaded on a fetch fault (must be word-aligned)

Ports:
- clk  in  1  single clock, all state on the rising edge
- rst  in  1  synchronous, active-high reset
- pc_current  out  PC_W  registered PC; to incrementer, PMP checker and imem_addr
- pc_next  in  PC_W  incrementer result (pc_current+4, mod 2^PC_W)
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_W  redirect target
- stall  in  1  decode cannot accept instr this cycle
- pmp_x_ok  in  1  PMP execute permission for pc_current (combinational)
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  equals pc_current
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  INSTR_W  read data
- instr_valid  out  1  instr_data/instr_pc valid for decode
- instr_data  out  INSTR_W  fetched instruction (registered)
- instr_pc  out  PC_W  PC of instr_data
- fetch_fault  out  1  one-cycle fault pulse
- fault_cause  out  1  0 = PMP execute deny, 1 = misaligned redirect
- fault_pc  out  PC_W  faulting address, held until the next fault
- fetch_count  out  16  delivered-instruction counter (see Optional Feature)

Behaviour:
- States: S_REQ, S_WAIT, S_HOLD, S_FAULT.
- Reset (rst=1 at an edge):
  - pc_current=RESET_PC; state=S_REQ.
  - instr_valid=0, instr_data=0, instr_pc=0, fetch_fault=0, fault_cause=0, fault_pc=0, fetch_count=0.
  - rst overrides everything, including an outstanding imem transaction. Any rvalid arriving after reset while in S_REQ is ignored.
- imem_req = (state==S_REQ) & pmp_x_ok & !redirect_valid & !rst. Combinational; imem_addr=pc_current.
- S_REQ:
  - redirect_valid with redirect_pc[1:0]==0: pc<=redirect_pc, stay in S_REQ.
  - redirect_valid with redirect_pc[1:0]!=0: fault, cause=1, fault_pc<=redirect_pc.
  - Else if !pmp_x_ok: fault, cause=0, fault_pc<=pc_current.
  - Else if imem_gnt: go to S_WAIT.
- Fault action (registered):
  - fetch_fault=1 for exactly one cycle.
  - pc<=TRAP_VEC; state<=S_FAULT.
  - S_FAULT lasts one bubble cycle, then S_REQ.
  - A redirect in S_FAULT is ignored; the trap takes priority.
- S_WAIT, no redirect pending:
  - On imem_rvalid: instr_data<=imem_rdata, instr_pc<=pc_current, instr_valid<=1, pc<=pc_next, state<=S_HOLD.
- S_WAIT, redirect:
  - A redirect_valid in S_WAIT sets a kill flag. pc<=redirect_pc, or a misaligned fault taken when the data returns.
  - The data returned for a killed request is discarded (instr_valid stays 0) and the FSM goes to S_REQ.
  - Redirect in the same cycle as rvalid: data discarded, redirect applied, go to S_REQ.
- S_HOLD:
  - instr_valid=1; instr fields stable while stall=1.
  - stall=0: instr consumed at that edge; instr_valid<=0, state<=S_REQ.
  - redirect_valid (priority over stall): instr_valid<=0, pc<=redirect_pc (alignment check as in S_REQ), state<=S_REQ.
- Throughput: at most 1 instruction per 3 cycles with zero-wait imem (REQ+gnt, rvalid, HOLD). Fetch latency from gnt to instr_valid is 1 cycle plus imem wait.
- PC wraps: pc_next from 8'hFC is 8'h00. No fault on wrap.
- imem_gnt and imem_rvalid outside the states that expect them are ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: fetch_count increments by 1 at every edge where instr_valid=1 and stall=0 and no redirect is present (i.e. the instruction is delivered). It saturates at 16'hFFFF and is cleared by rst.
- Undefined: fetch_count is tied to 16'h0000 and the counter logic is not built. The port list is unchanged.

Test Plan:
- Reset then zero-wait imem (gnt on req, rvalid the next cycle), stall=0, pmp_x_ok=1 -> instr_pc sequence 00,04,08 with instr_valid pulses 3 cycles apart; imem_addr matches.
- Hold stall=1 for 4 cycles in S_HOLD with instr 0x00A00093 -> instr_valid stays 1 and data/pc are stable; pc_current already equals instr_pc+4; release -> next req at instr_pc+4.
- redirect_valid with redirect_pc=8'h40 in the same cycle as imem_rvalid in S_WAIT -> data discarded, no instr_valid, next imem_addr=8'h40.
- pmp_x_ok=0 at pc=8'h20 -> no imem_req, fetch_fault pulse 1 cycle, fault_cause=0, fault_pc=8'h20, next imem_addr=TRAP_VEC (8'hF0) after 1 bubble.
- redirect_pc=8'h42 -> fetch_fault, fault_cause=1, fault_pc=8'h42, PC goes to 8'hF0. Separately, a fetch at 8'hFC -> next fetch at 8'h00.
- With FETCH_PERF_CNT_EN: 5 delivered instructions -> fetch_count=5, stalled cycles are not counted, rst clears it to 0. Without the macro: fetch_count=0 throughout.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and single-outstanding instruction-fetch sequencer with PMP/alignment faulting.
// Optional delivered-instruction counter is built only when FETCH_PERF_CNT_EN is defined.
`default_nettype none

module pc_fetch_ctrl #(
    parameter int                PC_W     = 8,
    parameter int                INSTR_W  = 32,
    parameter logic [PC_W-1:0]   RESET_PC = 8'h00,
    parameter logic [PC_W-1:0]   TRAP_VEC = 8'hF0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_W-1:0]      pc_current,
    input  logic [PC_W-1:0]      pc_next,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    input  logic                 stall,
    input  logic                 pmp_x_ok,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic                 instr_valid,
    output logic [INSTR_W-1:0]   instr_data,
    output logic [PC_W-1:0]      instr_pc,
    output logic                 fetch_fault,
    output logic                 fault_cause,
    output logic [PC_W-1:0]      fault_pc,
    output logic [15:0]          fetch_count
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               kill_q, kill_d;
    logic               iv_q, iv_d;
    logic [INSTR_W-1:0] idata_q, idata_d;
    logic [PC_W-1:0]    ipc_q, ipc_d;
    logic               fault_q, fault_d;
    logic               cause_q, cause_d;
    logic [PC_W-1:0]    fpc_q, fpc_d;

    logic               take_fault;
    logic               f_cause;
    logic [PC_W-1:0]    f_addr;
    logic               redir_mis;

    assign redir_mis = (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        iv_d       = iv_q;
        idata_d    = idata_q;
        ipc_d      = ipc_q;
        fault_d    = 1'b0;
        cause_d    = cause_q;
        fpc_d      = fpc_q;
        take_fault = 1'b0;
        f_cause    = 1'b0;
        f_addr     = pc_q;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    if (redir_mis) begin
                        take_fault = 1'b1;
                        f_cause    = 1'b1;
                        f_addr     = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!pmp_x_ok) begin
                    take_fault = 1'b1;
                    f_cause    = 1'b0;
                    f_addr     = pc_q;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                    kill_d  = 1'b0;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    kill_d  = 1'b0;
                    if (redirect_valid) begin
                        if (redir_mis) begin
                            take_fault = 1'b1;
                            f_cause    = 1'b1;
                            f_addr     = redirect_pc;
                        end else begin
                            pc_d = redirect_pc;
                        end
                    end else if (kill_q) begin
                        // A killed request may carry a misaligned target parked in the PC.
                        if (pc_q[1:0] != 2'b00) begin
                            take_fault = 1'b1;
                            f_cause    = 1'b1;
                            f_addr     = pc_q;
                        end
                    end else begin
                        idata_d = imem_rdata;
                        ipc_d   = pc_q;
                        iv_d    = 1'b1;
                        pc_d    = pc_next;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    pc_d   = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    iv_d    = 1'b0;
                    state_d = S_REQ;
                    if (redir_mis) begin
                        take_fault = 1'b1;
                        f_cause    = 1'b1;
                        f_addr     = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall) begin
                    iv_d    = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_FAULT: begin
                state_d = S_REQ;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (take_fault) begin
            fault_d = 1'b1;
            cause_d = f_cause;
            fpc_d   = f_addr;
            pc_d    = TRAP_VEC;
            state_d = S_FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            iv_q    <= 1'b0;
            idata_q <= '0;
            ipc_q   <= '0;
            fault_q <= 1'b0;
            cause_q <= 1'b0;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            iv_q    <= iv_d;
            idata_q <= idata_d;
            ipc_q   <= ipc_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            fpc_q   <= fpc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else if (iv_q && !stall && !redirect_valid && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fetch_count = cnt_q;
`else
    assign fetch_count = 16'h0000;
`endif

    assign imem_req    = (state_q == S_REQ) & pmp_x_ok & ~redirect_valid & ~rst;
    assign imem_addr   = pc_q;
    assign pc_current  = pc_q;
    assign instr_valid = iv_q;
    assign instr_data  = idata_q;
    assign instr_pc    = ipc_q;
    assign fetch_fault = fault_q;
    assign fault_cause = cause_q;
    assign fault_pc    = fpc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed vector table, counter sequence, and randomized run against a behavioural fetch model.
`default_nettype none

module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pc_current;
    logic [7:0]  pc_next;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        stall;
    logic        pmp_x_ok;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [7:0]  instr_pc;
    logic        fetch_fault;
    logic        fault_cause;
    logic [7:0]  fault_pc;
    logic [15:0] fetch_count;

    always #5 clk = ~clk;

    assign pc_next = pc_current + 8'd4;

    pc_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pc_current     (pc_current),
        .pc_next        (pc_next),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .pmp_x_ok       (pmp_x_ok),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault),
        .fault_cause    (fault_cause),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

`ifdef FETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic drive(input logic rv, input logic [7:0] rpc, input logic st, input logic pmp,
                         input logic gnt, input logic rval, input logic [31:0] rdata);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        pmp_x_ok       = pmp;
        imem_gnt       = gnt;
        imem_rvalid    = rval;
        imem_rdata     = rdata;
    endtask

    task automatic cyc(input logic rv, input logic [7:0] rpc, input logic st, input logic pmp,
                       input logic gnt, input logic rval, input logic [31:0] rdata);
        drive(rv, rpc, st, pmp, gnt, rval, rdata);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic fetch_one(input int n_stall);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, $urandom);
        for (int k = 0; k < n_stall; k++) cyc(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // Directed vectors: inputs for one cycle and the outputs expected during that cycle.
    typedef struct {
        logic        rv;
        logic [7:0]  rpc;
        logic        st, pmp, gnt, rval;
        logic [31:0] rdata;
        logic [7:0]  e_pc;
        logic        e_req, e_iv;
        logic [7:0]  e_ipc;
        logic [31:0] e_idata;
        logic        e_ff, e_fc;
        logic [7:0]  e_fpc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rv, input logic [7:0] rpc, input logic st, input logic pmp,
                       input logic gnt, input logic rval, input logic [31:0] rdata,
                       input logic [7:0] e_pc, input logic e_req, input logic e_iv,
                       input logic [7:0] e_ipc, input logic [31:0] e_idata,
                       input logic e_ff, input logic e_fc, input logic [7:0] e_fpc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.st = st; v.pmp = pmp; v.gnt = gnt; v.rval = rval; v.rdata = rdata;
        v.e_pc = e_pc; v.e_req = e_req; v.e_iv = e_iv; v.e_ipc = e_ipc; v.e_idata = e_idata;
        v.e_ff = e_ff; v.e_fc = e_fc; v.e_fpc = e_fpc;
        vq.push_back(v);
    endtask

    // Reference model: tracks whether a request is in flight, an instruction is held, or a trap bubble is due.
    logic [7:0]  m_pc, m_ipc, m_fpc;
    logic [31:0] m_idata;
    logic        m_busy, m_killed, m_have, m_trap, m_ff, m_fc;
    int          m_cnt;

    task automatic m_reset();
        m_pc = 8'h00; m_ipc = 8'h00; m_fpc = 8'h00; m_idata = 32'h0;
        m_busy = 0; m_killed = 0; m_have = 0; m_trap = 0; m_ff = 0; m_fc = 0; m_cnt = 0;
    endtask

    task automatic m_fault(input logic cause, input logic [7:0] addr);
        m_ff = 1; m_fc = cause; m_fpc = addr; m_pc = 8'hF0; m_trap = 1;
    endtask

    task automatic m_redirect_now(input logic [7:0] rpc);
        if (rpc % 4 != 0) m_fault(1'b1, rpc);
        else m_pc = rpc;
    endtask

    task automatic m_step(input logic rv, input logic [7:0] rpc, input logic st, input logic pmp,
                          input logic gnt, input logic rval, input logic [31:0] rdata);
        m_ff = 0;
        if (m_trap) begin
            m_trap = 0;
        end else if (m_have) begin
            if (rv) begin
                m_have = 0;
                m_redirect_now(rpc);
            end else if (!st) begin
                m_have = 0;
                if (m_cnt < 65535) m_cnt++;
            end
        end else if (m_busy) begin
            if (rval) begin
                m_busy = 0;
                if (rv) m_redirect_now(rpc);
                else if (m_killed) begin
                    if (m_pc % 4 != 0) m_fault(1'b1, m_pc);
                end else begin
                    m_have = 1; m_idata = rdata; m_ipc = m_pc; m_pc = m_pc + 8'd4;
                end
                m_killed = 0;
            end else if (rv) begin
                m_pc = rpc; m_killed = 1;
            end
        end else begin
            if (rv) m_redirect_now(rpc);
            else if (!pmp) m_fault(1'b0, m_pc);
            else if (gnt) begin
                m_busy = 1; m_killed = 0;
            end
        end
    endtask

    initial begin
        logic        rv, st, pmp, gnt, rval, do_rst;
        logic [7:0]  rpc;
        logic [31:0] rdata;
        logic        e_req;

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        check("rst_pc",     {24'h0, pc_current},  32'h00);
        check("rst_req",    {31'h0, imem_req},    32'h0);
        check("rst_iv",     {31'h0, instr_valid}, 32'h0);
        check("rst_idata",  instr_data,           32'h0);
        check("rst_ipc",    {24'h0, instr_pc},    32'h0);
        check("rst_ff",     {31'h0, fetch_fault}, 32'h0);
        check("rst_fc",     {31'h0, fault_cause}, 32'h0);
        check("rst_fpc",    {24'h0, fault_pc},    32'h0);
        check("rst_cnt",    {16'h0, fetch_count}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        //  rv rpc   st pmp gnt rval rdata          | pc   req iv ipc   idata          ff fc fpc
        add(0, 8'h00, 0, 1, 1, 1, 32'h0,          8'h00, 1, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 1, 32'h1000_00A0,  8'h00, 0, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 1, 1, 32'h0,          8'h04, 0, 1, 8'h00, 32'h1000_00A0,  0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 1, 0, 32'h0,          8'h04, 1, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 1, 32'h1000_00A4,  8'h04, 0, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0,          8'h08, 0, 1, 8'h04, 32'h1000_00A4,  0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 1, 0, 32'h0,          8'h08, 1, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 1, 32'h00A0_0093,  8'h08, 0, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        for (int i = 0; i < 4; i++)
            add(0, 8'h00, 1, 1, 0, 0, 32'h0,      8'h0C, 0, 1, 8'h08, 32'h00A0_0093,  0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0,          8'h0C, 0, 1, 8'h08, 32'h00A0_0093,  0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 1, 0, 32'h0,          8'h0C, 1, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(1, 8'h40, 0, 1, 0, 1, 32'hDEAD_BEEF,  8'h0C, 0, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0,          8'h40, 1, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 1, 0, 32'h0,          8'h40, 1, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(0, 8'h00, 0, 1, 0, 1, 32'h1000_0B40,  8'h40, 0, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(1, 8'h20, 1, 1, 0, 0, 32'h0,          8'h44, 0, 1, 8'h40, 32'h1000_0B40,  0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 1, 0, 32'h0,          8'h20, 0, 0, 8'h00, 32'h0,          0, 0, 8'h00);
        add(1, 8'h80, 0, 1, 1, 1, 32'h0,          8'hF0, 0, 0, 8'h00, 32'h0,          1, 0, 8'h20);
        add(1, 8'h42, 0, 1, 0, 0, 32'h0,          8'hF0, 0, 0, 8'h00, 32'h0,          0, 0, 8'h20);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0,          8'hF0, 0, 0, 8'h00, 32'h0,          1, 1, 8'h42);
        add(1, 8'hFC, 0, 1, 0, 0, 32'h0,          8'hF0, 0, 0, 8'h00, 32'h0,          0, 1, 8'h42);
        add(0, 8'h00, 0, 1, 1, 0, 32'h0,          8'hFC, 1, 0, 8'h00, 32'h0,          0, 1, 8'h42);
        add(0, 8'h00, 0, 1, 0, 1, 32'h1000_0BFC,  8'hFC, 0, 0, 8'h00, 32'h0,          0, 1, 8'h42);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0,          8'h00, 0, 1, 8'hFC, 32'h1000_0BFC,  0, 1, 8'h42);
        add(0, 8'h00, 0, 1, 0, 0, 32'h0,          8'h00, 1, 0, 8'h00, 32'h0,          0, 1, 8'h42);

        foreach (vq[i]) begin
            drive(vq[i].rv, vq[i].rpc, vq[i].st, vq[i].pmp, vq[i].gnt, vq[i].rval, vq[i].rdata);
            #1;
            check($sformatf("vec%0d_pc", i),   {24'h0, pc_current}, {24'h0, vq[i].e_pc});
            check($sformatf("vec%0d_addr", i), {24'h0, imem_addr},  {24'h0, vq[i].e_pc});
            check($sformatf("vec%0d_req", i),  {31'h0, imem_req},   {31'h0, vq[i].e_req});
            check($sformatf("vec%0d_iv", i),   {31'h0, instr_valid}, {31'h0, vq[i].e_iv});
            if (vq[i].e_iv) begin
                check($sformatf("vec%0d_ipc", i),   {24'h0, instr_pc}, {24'h0, vq[i].e_ipc});
                check($sformatf("vec%0d_idata", i), instr_data,        vq[i].e_idata);
            end
            check($sformatf("vec%0d_ff", i),  {31'h0, fetch_fault}, {31'h0, vq[i].e_ff});
            check($sformatf("vec%0d_fc", i),  {31'h0, fault_cause}, {31'h0, vq[i].e_fc});
            check($sformatf("vec%0d_fpc", i), {24'h0, fault_pc},    {24'h0, vq[i].e_fpc});
            @(posedge clk); #1;
        end

        // Delivered-instruction counter: stalled hold cycles must not count.
        do_reset();
        fetch_one(0);
        fetch_one(3);
        check("cnt_after2", {16'h0, fetch_count}, CNT_EN ? 32'd2 : 32'd0);
        fetch_one(1);
        fetch_one(2);
        fetch_one(0);
        check("cnt_after5", {16'h0, fetch_count}, CNT_EN ? 32'd5 : 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("cnt_rst", {16'h0, fetch_count}, 32'd0);
        rst = 1'b0;

        // Randomized traffic against the model, with occasional mid-run resets.
        do_reset();
        m_reset();
        for (int c = 0; c < 1500; c++) begin
            do_rst = ($urandom_range(0, 199) == 0);
            rv     = ($urandom_range(0, 7) == 0);
            rpc    = 8'($urandom);
            if ($urandom_range(0, 2) != 0) rpc[1:0] = 2'b00;
            st     = ($urandom_range(0, 2) == 0);
            pmp    = ($urandom_range(0, 15) != 0);
            gnt    = 1'($urandom_range(0, 1));
            rval   = ($urandom_range(0, 2) != 0);
            rdata  = $urandom;
            rst    = do_rst;
            drive(rv, rpc, st, pmp, gnt, rval, rdata);
            #1;
            e_req = !do_rst && !m_busy && !m_have && !m_trap && pmp && !rv;
            check("rnd_pc",  {24'h0, pc_current},  {24'h0, m_pc});
            check("rnd_req", {31'h0, imem_req},    {31'h0, e_req});
            check("rnd_iv",  {31'h0, instr_valid}, {31'h0, m_have});
            if (m_have) begin
                check("rnd_ipc",   {24'h0, instr_pc}, {24'h0, m_ipc});
                check("rnd_idata", instr_data,        m_idata);
            end
            check("rnd_ff",  {31'h0, fetch_fault}, {31'h0, m_ff});
            check("rnd_fc",  {31'h0, fault_cause}, {31'h0, m_fc});
            check("rnd_fpc", {24'h0, fault_pc},    {24'h0, m_fpc});
            check("rnd_cnt", {16'h0, fetch_count}, CNT_EN ? 32'(m_cnt) : 32'd0);
            @(posedge clk);
            if (do_rst) m_reset();
            else m_step(rv, rpc, st, pmp, gnt, rval, rdata);
            #1;
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
